// File: rtl/avalon_msg_len_limiter.sv
// Message length limiter: zero-latency pass-through that truncates messages longer than
// MAX_MSG_WORDS beats and reports the delivered length of every completed message.
module avalon_msg_len_limiter #(
    parameter int  DATA_WIDTH_IN_BYTES = 16,
    parameter int  MAX_MSG_WORDS       = 64,
    localparam int DW    = DATA_WIDTH_IN_BYTES * 8,
    localparam int EW    = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1,
    localparam int CNT_W = $clog2(MAX_MSG_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_msg_data_i,
    input  logic             in_msg_valid_i,
    input  logic             in_msg_sop_i,
    input  logic             in_msg_eop_i,
    input  logic [EW-1:0]    in_msg_empty_i,
    output logic             in_msg_rdy_o,
    output logic [DW-1:0]    out_msg_data_o,
    output logic             out_msg_valid_o,
    output logic             out_msg_sop_o,
    output logic             out_msg_eop_o,
    output logic [EW-1:0]    out_msg_empty_o,
    input  logic             out_msg_rdy_i,
    output logic [CNT_W-1:0] msg_len_words,
    output logic             msg_len_valid,
    output logic             too_long_error
);

    typedef enum logic [1:0] {IDLE, IN_MSG, DROP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              len_vld_q, len_vld_d;
    logic              err_q, err_d;

    logic fwd_path, xfer, trunc;

    // A beat takes the forwarding path when it belongs to a message; everything else is swallowed.
    assign fwd_path = (state_q == IN_MSG) || (state_q == IDLE && in_msg_sop_i);
    assign in_msg_rdy_o = fwd_path ? out_msg_rdy_i : 1'b1;
    assign xfer = in_msg_valid_i && in_msg_rdy_o;

    // Last allowed beat of a message that has not ended by itself.
    assign trunc = fwd_path && !in_msg_eop_i &&
                   ((state_q == IDLE) ? (MAX_MSG_WORDS == 1)
                                      : (beat_cnt_q == CNT_W'(MAX_MSG_WORDS - 1)));

    assign out_msg_valid_o = in_msg_valid_i && fwd_path;
    assign out_msg_data_o  = in_msg_data_i;
    assign out_msg_sop_o   = in_msg_sop_i && (state_q == IDLE);
    assign out_msg_eop_o   = in_msg_eop_i || trunc;
    assign out_msg_empty_o = trunc ? '0 : in_msg_empty_i;

    assign msg_len_words  = len_q;
    assign msg_len_valid  = len_vld_q;
    assign too_long_error = err_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        len_vld_d  = 1'b0;
        err_d      = 1'b0;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (in_msg_sop_i) begin
                        if (in_msg_eop_i) begin
                            len_vld_d = 1'b1;
                            len_d     = CNT_W'(1);
                        end else if (trunc) begin
                            len_vld_d = 1'b1;
                            err_d     = 1'b1;
                            len_d     = CNT_W'(MAX_MSG_WORDS);
                            state_d   = DROP;
                        end else begin
                            beat_cnt_d = CNT_W'(1);
                            state_d    = IN_MSG;
                        end
                    end
                end
                IN_MSG: begin
                    if (in_msg_eop_i) begin
                        len_vld_d  = 1'b1;
                        len_d      = beat_cnt_q + 1'b1;
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else if (trunc) begin
                        len_vld_d  = 1'b1;
                        err_d      = 1'b1;
                        len_d      = CNT_W'(MAX_MSG_WORDS);
                        beat_cnt_d = '0;
                        state_d    = DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                DROP: begin
                    if (in_msg_eop_i) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            len_vld_q  <= len_vld_d;
            err_q      <= err_d;
        end
    end

endmodule
